// File: rtl/video_pkg.sv
// ----------------------------------------------------------------------------
// video_pkg
//   Shared definitions for the packed 24bpp pixel stream.
//   - Packing constants: 4 bytes per word, 3 bytes per pixel, so a group of
//     3 words carries exactly 4 pixels.
//   - rgb_t: one pixel, 8 bits per colour component.
//   - phase_t: position of a word inside its 3-word group.
// ----------------------------------------------------------------------------
package video_pkg;

    localparam int BYTES_PER_WORD   = 4;
    localparam int BYTES_PER_PIXEL  = 3;
    localparam int WORDS_PER_GROUP  = 3;
    localparam int PIXELS_PER_GROUP = BYTES_PER_WORD * WORDS_PER_GROUP / BYTES_PER_PIXEL;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2
    } phase_t;

    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            P0:      n = P1;
            P1:      n = P2;
            default: n = P0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// ----------------------------------------------------------------------------
// pixel_pos_counter
//   Assigns x/y positions to pixels as they are loaded into the output stage
//   of pixel_unpacker, decides end-of-line, checks the stream framing against
//   the nominal geometry and generates the end-of-frame pulse.
//
// Ports
//   aclk, areset   clock, asynchronous active-high reset
//   load           a pixel is being loaded into the output stage this cycle
//   restart        that pixel starts a frame (tuser word): position forced to (0,0)
//   tlast_end      that pixel is the last pixel of a word carrying tlast
//   out_accept     output pixel handshake (pix_valid & pix_ready)
//   out_eol/out_y  eol flag and row of the pixel currently in the output stage
//   cur_x/cur_y    position of the pixel being loaded
//   cur_eol        eol flag of the pixel being loaded
//   err_eol        sticky: tlast disagreed with the nominal line length
//   err_sof        sticky: tuser seen away from the expected frame start
//   frame_done     1-cycle pulse after the last eol pixel of a frame is accepted
// ----------------------------------------------------------------------------
module pixel_pos_counter #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int XW           = 11,
    parameter int YW           = 10
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          load,
    input  logic          restart,
    input  logic          tlast_end,
    input  logic          out_accept,
    input  logic          out_eol,
    input  logic [YW-1:0] out_y,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          cur_eol,
    output logic          err_eol,
    output logic          err_sof,
    output logic          frame_done
);

    localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

    // Position the next loaded pixel will get if no resync happens.
    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic          at_wrap;

    assign cur_x   = restart ? '0 : x_reg;
    assign cur_y   = restart ? '0 : y_reg;
    assign at_wrap = (cur_x == X_LAST);
    // A line ends either at the nominal width or where tlast says it does;
    // disagreement between the two is the eol framing error.
    assign cur_eol = at_wrap | tlast_end;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            x_reg      <= '0;
            y_reg      <= '0;
            err_eol    <= 1'b0;
            err_sof    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (load) begin
                if (cur_eol) begin
                    x_reg <= '0;
                    y_reg <= (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
                end else begin
                    x_reg <= cur_x + XW'(1);
                    y_reg <= cur_y;
                end
                if (restart && (x_reg != '0 || y_reg != '0)) begin
                    err_sof <= 1'b1;
                end
                if (at_wrap != tlast_end) begin
                    err_eol <= 1'b1;
                end
            end
            frame_done <= out_accept & out_eol & (out_y == Y_LAST);
        end
    end

endmodule

// File: rtl/pixel_unpacker.sv
// ----------------------------------------------------------------------------
// pixel_unpacker
//   AXI4-Stream sink for a packed 24bpp stream (4 pixels per 3 words).
//   Unpacks words into one pixel per handshake, tagging each pixel with
//   sof/eol and its x/y position, and flags framing errors.
//
// Ports
//   aclk, areset        clock, asynchronous active-high reset
//   in_stream_*         32-bit AXI4-Stream input (tuser = SOF, tlast = EOL);
//                       tkeep is not used
//   r, g, b             pixel colour of the output stage
//   pix_valid/pix_ready output handshake
//   pix_sof, pix_eol    frame start / line end markers of the output pixel
//   pix_x, pix_y        position of the output pixel
//   err_eol, err_sof    sticky framing error flags
//   frame_done          pulse after the last pixel of a frame is accepted
// ----------------------------------------------------------------------------
module pixel_unpacker
    import video_pkg::*;
#(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int XW           = 11,
    parameter int YW           = 10
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic [31:0]   in_stream_tdata,
    input  logic [3:0]    in_stream_tkeep,
    input  logic          in_stream_tlast,
    input  logic          in_stream_tuser,
    input  logic          in_stream_tvalid,
    output logic          in_stream_tready,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          err_eol,
    output logic          err_sof,
    output logic          frame_done
);

    logic unused_tkeep;
    assign unused_tkeep = &{1'b0, in_stream_tkeep};

    // run_reg keeps tready low while reset is asserted and for the first
    // clock after release.
    logic       run_reg;
    logic       synced_reg;
    phase_t     phase_reg;
    logic [7:0] res0_reg;
    logic [7:0] res1_reg;
    logic       pend_valid_reg;
    rgb_t       pend_pix_reg;
    logic       pend_last_reg;

    logic [7:0] word_byte [BYTES_PER_WORD];

    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_bytes
            assign word_byte[gi] = in_stream_tdata[8*gi +: 8];
        end
    endgenerate

    logic          word_acc;
    logic          word_use;
    logic          pix_acc;
    logic          pend_drain;
    logic          load;
    phase_t        eff_phase;
    rgb_t          word_pix;
    rgb_t          load_pix;
    logic          word_pix_last;
    logic          restart;
    logic          tlast_end;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          cur_eol;

    assign in_stream_tready = run_reg & ~pend_valid_reg & (~pix_valid | pix_ready);

    assign word_acc   = in_stream_tvalid & in_stream_tready;
    // Words before the first tuser after reset are swallowed silently.
    assign word_use   = word_acc & (synced_reg | in_stream_tuser);
    assign pix_acc    = pix_valid & pix_ready;
    assign pend_drain = pend_valid_reg & pix_acc;
    assign load       = word_use | pend_drain;

    // A tuser word always starts a new group, whatever phase we were in.
    assign eff_phase     = in_stream_tuser ? P0 : phase_reg;
    // Only a P2 word carries a second pixel (held in pend), so otherwise the
    // word's first pixel is also its last.
    assign word_pix_last = (eff_phase != P2);

    always_comb begin
        word_pix = '{r: word_byte[0], g: word_byte[1], b: word_byte[2]};
        case (eff_phase)
            P1:      word_pix = '{r: res0_reg, g: word_byte[0], b: word_byte[1]};
            P2:      word_pix = '{r: res0_reg, g: res1_reg, b: word_byte[0]};
            default: word_pix = '{r: word_byte[0], g: word_byte[1], b: word_byte[2]};
        endcase
    end

    assign load_pix  = word_use ? word_pix : pend_pix_reg;
    assign restart   = word_use & in_stream_tuser;
    assign tlast_end = word_use ? (in_stream_tlast & word_pix_last) : pend_last_reg;

    pixel_pos_counter #(
        .FRAME_WIDTH  (FRAME_WIDTH),
        .FRAME_HEIGHT (FRAME_HEIGHT),
        .XW           (XW),
        .YW           (YW)
    ) u_pos (
        .aclk       (aclk),
        .areset     (areset),
        .load       (load),
        .restart    (restart),
        .tlast_end  (tlast_end),
        .out_accept (pix_acc),
        .out_eol    (pix_eol),
        .out_y      (pix_y),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .cur_eol    (cur_eol),
        .err_eol    (err_eol),
        .err_sof    (err_sof),
        .frame_done (frame_done)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            run_reg        <= 1'b0;
            synced_reg     <= 1'b0;
            phase_reg      <= P0;
            res0_reg       <= '0;
            res1_reg       <= '0;
            pend_valid_reg <= 1'b0;
            pend_pix_reg   <= '0;
            pend_last_reg  <= 1'b0;
            pix_valid      <= 1'b0;
            r              <= '0;
            g              <= '0;
            b              <= '0;
            pix_sof        <= 1'b0;
            pix_eol        <= 1'b0;
            pix_x          <= '0;
            pix_y          <= '0;
        end else begin
            run_reg <= 1'b1;

            if (word_use) begin
                synced_reg <= 1'b1;
                phase_reg  <= in_stream_tlast ? P0 : next_phase(eff_phase);
                case (eff_phase)
                    P0: res0_reg <= word_byte[3];
                    P1: begin
                        res0_reg <= word_byte[2];
                        res1_reg <= word_byte[3];
                    end
                    default: begin
                        // Fourth pixel of the group waits behind pixel C.
                        pend_valid_reg <= 1'b1;
                        pend_pix_reg   <= '{r: word_byte[1], g: word_byte[2], b: word_byte[3]};
                        pend_last_reg  <= in_stream_tlast;
                    end
                endcase
            end else if (pend_drain) begin
                pend_valid_reg <= 1'b0;
            end

            if (load) begin
                pix_valid <= 1'b1;
                r         <= load_pix.r;
                g         <= load_pix.g;
                b         <= load_pix.b;
                pix_sof   <= restart;
                pix_eol   <= cur_eol;
                pix_x     <= cur_x;
                pix_y     <= cur_y;
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end
        end
    end

endmodule
